// File: rtl/kf6845_register_loader.sv
// Bus initiator that queues register read/write commands and plays them out as
// two-phase KF6845 accesses. Define KF6845_LOADER_ADDR_CACHE_EN to skip redundant address phases.
module kf6845_register_loader #(
   parameter int unsigned ENABLE_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [4:0] req_addr,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       CS_N,
   output logic       RS,
   output logic       ENABLE,
   output logic       R_OR_W,
   output logic [7:0] bus_data_out,
   input  logic [7:0] bus_data_in
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;

   typedef struct packed {
      logic       wr;
      logic [4:0] addr;
      logic [7:0] data;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

   cmd_t            mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q;
   logic            push, pop, empty;
   cmd_t            head;

   state_t          state_q, state_d;
   logic            phase_q, phase_d;
   logic [SW-1:0]   scnt_q, scnt_d;
   cmd_t            cmd_q, cmd_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            load_now, hit;

`ifdef KF6845_LOADER_ADDR_CACHE_EN
   logic            cache_v_q, cache_v_d;
   logic [4:0]      cache_a_q, cache_a_d;
`endif

   assign empty     = (count_q == '0);
   assign push      = req_valid & ~full_q;
   assign head      = mem_q[rd_ptr_q];
   assign req_ready = ~full_q;

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {req_write, req_addr, req_data};
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(FIFO_DEPTH));
      end
   end

`ifdef KF6845_LOADER_ADDR_CACHE_EN
   assign hit = cache_v_q && (cache_a_q == head.addr);
`else
   assign hit = 1'b0;
`endif

   // A new command loads from IDLE or straight out of the GAP that ends a data phase.
   assign load_now = ~empty && ((state_q == IDLE) || ((state_q == GAP) && phase_q));

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      scnt_d      = scnt_q;
      cmd_d       = cmd_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      pop         = 1'b0;
`ifdef KF6845_LOADER_ADDR_CACHE_EN
      cache_v_d   = cache_v_q;
      cache_a_d   = cache_a_q;
`endif
      unique case (state_q)
         IDLE: state_d = IDLE;
         SETUP: begin
            state_d = STROBE;
            scnt_d  = '0;
         end
         STROBE: begin
            if (scnt_q == SW'(ENABLE_CYCLES - 1)) begin
               state_d = HOLD;
               if (phase_q && !cmd_q.wr) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = bus_data_in;
               end
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end
         HOLD: state_d = GAP;
         GAP: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               state_d = SETUP;
`ifdef KF6845_LOADER_ADDR_CACHE_EN
               cache_v_d = 1'b1;
               cache_a_d = cmd_q.addr;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_now) begin
         pop     = 1'b1;
         cmd_d   = head;
         phase_d = hit;
         state_d = SETUP;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         scnt_q      <= '0;
         cmd_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
`ifdef KF6845_LOADER_ADDR_CACHE_EN
         cache_v_q   <= 1'b0;
         cache_a_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         scnt_q      <= scnt_d;
         cmd_q       <= cmd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
`ifdef KF6845_LOADER_ADDR_CACHE_EN
         cache_v_q   <= cache_v_d;
         cache_a_q   <= cache_a_d;
`endif
      end
   end

   always_comb begin
      CS_N         = 1'b1;
      ENABLE       = 1'b0;
      RS           = 1'b0;
      R_OR_W       = 1'b1;
      bus_data_out = 8'h00;
      if ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD)) begin
         CS_N   = 1'b0;
         ENABLE = (state_q == STROBE);
         RS     = phase_q;
         R_OR_W = phase_q & ~cmd_q.wr;
         if (!phase_q)      bus_data_out = {3'b000, cmd_q.addr};
         else if (cmd_q.wr) bus_data_out = cmd_q.data;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = ~empty || (state_q != IDLE);

endmodule

// File: tb/tb_kf6845_register_loader.sv
// Self-checking bench: a register-file device model answers the bus, and a
// command-level reference model predicts bus cycles and read responses.
module tb_kf6845_register_loader;

   localparam int unsigned E = 2;
   localparam int unsigned D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [4:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       req_ready, rsp_valid, busy, CS_N, RS, ENABLE, R_OR_W;
   logic [7:0] rsp_data, bus_data_out, bus_data_in;

   typedef struct {
      logic        rs;
      logic        rw;
      logic [7:0]  dout;
      int unsigned len;
   } cyc_t;

   cyc_t        obs_q[$];
   cyc_t        exp_q[$];
   logic [7:0]  rsp_obs[$];
   logic [7:0]  rsp_exp[$];
   logic [7:0]  dev_regs [32];
   logic [4:0]  dev_addr = '0;
   logic [7:0]  ref_regs [32];
`ifdef KF6845_LOADER_ADDR_CACHE_EN
   logic        cache_v = 1'b0;
   logic [4:0]  cache_a = '0;
`endif
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned busy_cnt = 0;
   bit          gap_chk = 1'b0;

   always #5 clock = ~clock;

   assign bus_data_in = dev_regs[dev_addr];

   kf6845_register_loader #(.ENABLE_CYCLES(E), .FIFO_DEPTH(D)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .CS_N(CS_N), .RS(RS), .ENABLE(ENABLE), .R_OR_W(R_OR_W),
      .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
   );

   function automatic logic [7:0] init_val(input int unsigned i);
      return (i == 14) ? 8'h3A : 8'(i * 37 + 5);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor and register-file device model.
   initial begin : monitor
      cyc_t        cur;
      bit          in_cyc;
      bit          had_cyc;
      int unsigned high_cnt;
      logic        prev_en;
      in_cyc = 1'b0; had_cyc = 1'b0; high_cnt = 0; prev_en = 1'b0;
      cur = '{1'b0, 1'b1, 8'h00, 0};
      for (int i = 0; i < 32; i++) dev_regs[i] = init_val(i);
      forever begin
         @(negedge clock);
         if (busy === 1'b1) busy_cnt++;
         if (rsp_valid === 1'b1) begin
            rsp_obs.push_back(rsp_data);
            chk("rsp_in_hold", 32'({CS_N, ENABLE, RS, R_OR_W, prev_en}), 32'(5'b00111));
         end
         if (CS_N === 1'b0) begin
            if (!in_cyc) begin
               if (gap_chk && had_cyc) chk("gap_one_clk", 32'(high_cnt), 32'(1));
               in_cyc = 1'b1;
               cur = '{RS, R_OR_W, bus_data_out, 0};
            end else begin
               chk("bus_stable", 32'({RS, R_OR_W, bus_data_out}), 32'({cur.rs, cur.rw, cur.dout}));
            end
            chk("enable_shape", 32'(ENABLE), 32'(cur.len >= 1 && cur.len <= E));
            cur.len++;
         end else begin
            if (in_cyc) begin
               in_cyc = 1'b0;
               had_cyc = gap_chk;
               high_cnt = 0;
               obs_q.push_back(cur);
               if (cur.len == E + 2 && !cur.rw) begin
                  if (!cur.rs) dev_addr = cur.dout[4:0];
                  else         dev_regs[dev_addr] = cur.dout;
               end
            end
            high_cnt++;
            chk("enable_idle", 32'(ENABLE), 32'(0));
         end
         prev_en = ENABLE;
      end
   end

   function automatic void model_push(input logic w, input logic [4:0] a, input logic [7:0] d);
      bit skip;
      skip = 1'b0;
`ifdef KF6845_LOADER_ADDR_CACHE_EN
      skip = cache_v && (cache_a == a);
      cache_v = 1'b1;
      cache_a = a;
`endif
      if (!skip) exp_q.push_back('{1'b0, 1'b0, {3'b000, a}, E + 2});
      exp_q.push_back('{1'b1, ~w, w ? d : 8'h00, E + 2});
      if (w) ref_regs[a] = d;
      else   rsp_exp.push_back(ref_regs[a]);
   endfunction

   task automatic push(input logic w, input logic [4:0] a, input logic [7:0] d);
      int unsigned t;
      t = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
      while (req_ready !== 1'b1 && t < 400) begin
         @(negedge clock);
         t++;
      end
      if (t >= 400) chk("push_timeout", 32'(t), 32'(0));
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned t;
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (busy !== 1'b0 && t < 600);
      chk("idle_timeout", 32'(busy), 32'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
`ifdef KF6845_LOADER_ADDR_CACHE_EN
      cache_v = 1'b0;
`endif
      obs_q.delete(); exp_q.delete(); rsp_obs.delete(); rsp_exp.delete();
   endtask

   task automatic cmp_bus(input string tag);
      chk({tag, "_ncycles"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s[%0d]_rs", tag, i), 32'(obs_q[i].rs), 32'(exp_q[i].rs));
         chk($sformatf("%s[%0d]_rw", tag, i), 32'(obs_q[i].rw), 32'(exp_q[i].rw));
         chk($sformatf("%s[%0d]_dout", tag, i), 32'(obs_q[i].dout), 32'(exp_q[i].dout));
         chk($sformatf("%s[%0d]_len", tag, i), 32'(obs_q[i].len), 32'(exp_q[i].len));
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic cmp_rsp(input string tag);
      chk({tag, "_nrsp"}, 32'(rsp_obs.size()), 32'(rsp_exp.size()));
      for (int i = 0; i < rsp_obs.size() && i < rsp_exp.size(); i++)
         chk($sformatf("%s_rsp[%0d]", tag, i), 32'(rsp_obs[i]), 32'(rsp_exp[i]));
      rsp_obs.delete(); rsp_exp.delete();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned b0, t, acc, act;
      bit          seen, found;
      logic        last, w;
      logic [4:0]  a;
      logic [7:0]  d;
      for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_cs_n", 32'(CS_N), 32'(1));
      chk("rst_enable", 32'(ENABLE), 32'(0));
      chk("rst_rs", 32'(RS), 32'(0));
      chk("rst_r_or_w", 32'(R_OR_W), 32'(1));
      chk("rst_bus_data_out", 32'(bus_data_out), 32'(8'h00));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_data", 32'(rsp_data), 32'(8'h00));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_req_ready", 32'(req_ready), 32'(1));

      // Single write of R0.
      b0 = busy_cnt;
      push(1'b1, 5'd0, 8'h71); model_push(1'b1, 5'd0, 8'h71);
      wait_idle();
      chk("wr_cmd_clocks", 32'(busy_cnt - b0 - 1), 32'(2 * (E + 3)));
      cmp_bus("wr");
      cmp_rsp("wr");

      // Read of R14; the device holds 0x3A there.
      push(1'b0, 5'd14, 8'h00); model_push(1'b0, 5'd14, 8'h00);
      wait_idle();
      cmp_bus("rd");
      cmp_rsp("rd");
      repeat (3) @(negedge clock);
      chk("rsp_data_hold", 32'(rsp_data), 32'(8'h3A));

      // Backpressure: six writes offered continuously.
      gap_chk = 1'b1; seen = 1'b0; acc = 0;
      for (int i = 0; i < 6; i++) begin
         if (req_ready === 1'b0 && !seen) begin
            seen = 1'b1;
            chk("ready_drop_depth", 32'(acc), 32'(D + 1));
         end
         a = 5'($urandom_range(31, 0)); d = 8'($urandom);
         push(1'b1, a, d); model_push(1'b1, a, d);
         acc++;
      end
      chk("ready_dropped", 32'(seen), 32'(1));
      wait_idle();
      gap_chk = 1'b0;
      cmp_bus("bp");

      // Two writes to R12 from a fresh reset.
      do_reset();
      b0 = busy_cnt;
      push(1'b1, 5'd12, 8'h12); model_push(1'b1, 5'd12, 8'h12);
      push(1'b1, 5'd12, 8'h34); model_push(1'b1, 5'd12, 8'h34);
      wait_idle();
`ifdef KF6845_LOADER_ADDR_CACHE_EN
      chk("r12_pair_clocks", 32'(busy_cnt - b0 - 1), 32'(3 * (E + 3)));
`else
      chk("r12_pair_clocks", 32'(busy_cnt - b0 - 1), 32'(4 * (E + 3)));
`endif
      cmp_bus("cache");

      // Random mix of reads and writes with random idle gaps.
      for (int i = 0; i < 24; i++) begin
         w = 1'($urandom_range(1, 0));
         a = 5'($urandom_range(31, 0));
         if ($urandom_range(3, 0) == 0) a = 5'd12;
         d = 8'($urandom);
         push(w, a, d); model_push(w, a, d);
         repeat ($urandom_range(3, 0)) @(negedge clock);
      end
      wait_idle();
      cmp_bus("rand");
      cmp_rsp("rand");

      // Reset on the second STROBE clock of a write with two commands queued.
      push(1'b1, 5'd3, 8'hA5);
      push(1'b1, 5'd4, 8'h5A);
      push(1'b1, 5'd5, 8'hC3);
      last = ENABLE; found = 1'b0; t = 0;
      while (!found && t < 40) begin
         @(negedge clock);
         t++;
         if (ENABLE === 1'b1 && last === 1'b1) found = 1'b1;
         else last = ENABLE;
      end
      chk("strobe2_found", 32'(found), 32'(1));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_cs_n", 32'(CS_N), 32'(1));
      chk("midrst_enable", 32'(ENABLE), 32'(0));
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_req_ready", 32'(req_ready), 32'(1));
      act = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (CS_N !== 1'b1 || rsp_valid !== 1'b0) act++;
      end
      chk("midrst_quiet", 32'(act), 32'(0));
      chk("midrst_no_rsp", 32'(rsp_obs.size()), 32'(0));
      obs_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
